// File: rtl/fast_vram_pkg.sv
// Shared constants and FSM state encoding for the fast VRAM arbiter slice.
package fast_vram_pkg;

    localparam int unsigned VRAM_AW = 11;
    localparam int unsigned VRAM_DW = 16;

    localparam logic [VRAM_AW-1:0] MOD_RESET = VRAM_AW'(1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_VRD1,
        ST_VRD2,
        ST_VACK,
        ST_CRD1,
        ST_CRD2,
        ST_CWR_S,
        ST_CWR_W,
        ST_CWR_H
    } vram_state_t;

endpackage

// File: rtl/fast_vram_cpu_port.sv
// CPU register port: address pointer with post-increment modulo, one-word
// write buffer and the pending-operation flags that form CPU_BUSY.
module fast_vram_cpu_port
    import fast_vram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               addr_wr,
    input  logic               mod_wr,
    input  logic               data_wr,
    input  logic [VRAM_DW-1:0] din,
    input  logic               wr_done,
    input  logic               rd_done,
    output logic [VRAM_AW-1:0] ptr,
    output logic [VRAM_DW-1:0] wbuf,
    output logic               wr_pend,
    output logic               rd_pend,
    output logic               busy
);

    logic [VRAM_AW-1:0] mod_q;
    logic [VRAM_AW-1:0] ptr_n;
    logic [VRAM_AW-1:0] mod_n;
    logic [VRAM_DW-1:0] wbuf_n;
    logic               wr_pend_n;
    logic               rd_pend_n;

    always_comb begin
        ptr_n     = ptr;
        mod_n     = mod_q;
        wbuf_n    = wbuf;
        wr_pend_n = wr_pend;
        rd_pend_n = rd_pend;
        if (!busy) begin
            if (mod_wr) begin
                mod_n = din[VRAM_AW-1:0];
            end
            if (addr_wr) begin
                ptr_n = din[VRAM_AW-1:0];
            end
            // A combined address+data strobe skips the prefetch: the write's
            // own post-increment prefetch follows anyway.
            if (data_wr) begin
                wbuf_n    = din;
                wr_pend_n = 1'b1;
            end else if (addr_wr) begin
                rd_pend_n = 1'b1;
            end
        end
        if (wr_done) begin
            ptr_n     = ptr + mod_q;
            wr_pend_n = 1'b0;
            rd_pend_n = 1'b1;
        end
        if (rd_done) begin
            rd_pend_n = 1'b0;
        end
    end

    // The pending flags stay set for the whole CPU access, so they alone
    // cover every CPU state of the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            mod_q   <= MOD_RESET;
            wbuf    <= '0;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ptr     <= ptr_n;
            mod_q   <= mod_n;
            wbuf    <= wbuf_n;
            wr_pend <= wr_pend_n;
            rd_pend <= rd_pend_n;
            busy    <= wr_pend_n | rd_pend_n;
        end
    end

endmodule

// File: rtl/fast_vram_arbiter.sv
// Fast VRAM sequencer: shares the 2048x16 async SRAM between video sprite
// fetches (priority, bounded streak) and the CPU register port.
module fast_vram_arbiter
    import fast_vram_pkg::*;
#(
    parameter int unsigned VID_STREAK_MAX = 2
) (
    input  logic               CLK_24M,
    input  logic               nRESET,
    input  logic               VID_REQ,
    input  logic [VRAM_AW-1:0] VID_ADDR,
    output logic               VID_ACK,
    output logic [VRAM_DW-1:0] VID_DATA,
    input  logic               CPU_ADDR_WR,
    input  logic               CPU_MOD_WR,
    input  logic               CPU_DATA_WR,
    input  logic [VRAM_DW-1:0] CPU_DIN,
    output logic [VRAM_DW-1:0] CPU_RDATA,
    output logic               CPU_BUSY,
    output logic [VRAM_AW-1:0] VRAM_ADDR,
    output logic [VRAM_DW-1:0] VRAM_DOUT,
    output logic               VRAM_DOE,
    input  logic [VRAM_DW-1:0] VRAM_DIN,
    output logic               nVRAM_CE,
    output logic               nVRAM_OE,
    output logic               nVRAM_WE
);

    localparam int unsigned STREAK_W =
        (VID_STREAK_MAX < 1) ? 1 : $clog2(VID_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(VID_STREAK_MAX);

    vram_state_t        state;
    logic [STREAK_W-1:0] streak;
    logic [VRAM_AW-1:0] ptr;
    logic [VRAM_DW-1:0] wbuf;
    logic               wr_pend;
    logic               rd_pend;
    logic               wr_done;
    logic               rd_done;
    logic               cpu_pend;
    logic               grant_vid;

    assign wr_done   = (state == ST_CWR_H);
    assign rd_done   = (state == ST_CRD2);
    assign cpu_pend  = wr_pend | rd_pend;
    assign grant_vid = VID_REQ & ~(cpu_pend & (streak == STREAK_LIM));

    fast_vram_cpu_port u_cpu_port (
        .clk     (CLK_24M),
        .rst_n   (nRESET),
        .addr_wr (CPU_ADDR_WR),
        .mod_wr  (CPU_MOD_WR),
        .data_wr (CPU_DATA_WR),
        .din     (CPU_DIN),
        .wr_done (wr_done),
        .rd_done (rd_done),
        .ptr     (ptr),
        .wbuf    (wbuf),
        .wr_pend (wr_pend),
        .rd_pend (rd_pend),
        .busy    (CPU_BUSY)
    );

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state     <= ST_IDLE;
            streak    <= '0;
            VRAM_ADDR <= '0;
            VRAM_DOUT <= '0;
            VRAM_DOE  <= 1'b0;
            nVRAM_CE  <= 1'b1;
            nVRAM_OE  <= 1'b1;
            nVRAM_WE  <= 1'b1;
            VID_ACK   <= 1'b0;
            VID_DATA  <= '0;
            CPU_RDATA <= '0;
        end else begin
            // Pins default to the bus-idle levels; each state re-asserts
            // what the following cycle needs.
            VID_ACK  <= 1'b0;
            VRAM_DOE <= 1'b0;
            nVRAM_CE <= 1'b1;
            nVRAM_OE <= 1'b1;
            nVRAM_WE <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (grant_vid) begin
                        state     <= ST_VRD1;
                        VRAM_ADDR <= VID_ADDR;
                        nVRAM_CE  <= 1'b0;
                        nVRAM_OE  <= 1'b0;
                        if (streak != STREAK_LIM) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else begin
                        streak <= '0;
                        if (wr_pend) begin
                            state     <= ST_CWR_S;
                            VRAM_ADDR <= ptr;
                            VRAM_DOUT <= wbuf;
                            VRAM_DOE  <= 1'b1;
                            nVRAM_CE  <= 1'b0;
                        end else if (rd_pend) begin
                            state     <= ST_CRD1;
                            VRAM_ADDR <= ptr;
                            nVRAM_CE  <= 1'b0;
                            nVRAM_OE  <= 1'b0;
                        end
                    end
                end
                ST_VRD1: begin
                    state    <= ST_VRD2;
                    nVRAM_CE <= 1'b0;
                    nVRAM_OE <= 1'b0;
                end
                ST_VRD2: begin
                    state    <= ST_VACK;
                    VID_DATA <= VRAM_DIN;
                    VID_ACK  <= 1'b1;
                end
                ST_VACK: begin
                    state <= ST_IDLE;
                end
                ST_CRD1: begin
                    state    <= ST_CRD2;
                    nVRAM_CE <= 1'b0;
                    nVRAM_OE <= 1'b0;
                end
                ST_CRD2: begin
                    state     <= ST_IDLE;
                    CPU_RDATA <= VRAM_DIN;
                end
                ST_CWR_S: begin
                    state    <= ST_CWR_W;
                    VRAM_DOE <= 1'b1;
                    nVRAM_CE <= 1'b0;
                    nVRAM_WE <= 1'b0;
                end
                ST_CWR_W: begin
                    state    <= ST_CWR_H;
                    VRAM_DOE <= 1'b1;
                    nVRAM_CE <= 1'b0;
                end
                ST_CWR_H: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
